// File: rtl/sram_tp_rd_unpacker.sv
// Read-side unpacker for the two-port SRAM: fetches a run of words and streams
// each word out lane by lane (lane 0 first) over a valid/ready column interface.
module sram_tp_rd_unpacker #(
    parameter int ADR_WD = 5,
    parameter int DAT_WD = 64,
    parameter int COL_WD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADR_WD-1:0] base_adr_i,
    input  logic [ADR_WD:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_ena_o,
    output logic [ADR_WD-1:0] rd_adr_o,
    input  logic [DAT_WD-1:0] rd_dat_i,
    output logic              col_val_o,
    output logic [COL_WD-1:0] col_dat_o,
    output logic              col_lst_o,
    input  logic              col_rdy_i
);

    localparam int NUM_COL = DAT_WD / COL_WD;
    localparam int CNT_WD  = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

    state_e              state_q;
    logic [ADR_WD-1:0]   base_q;
    logic [ADR_WD:0]     len_q;
    logic [ADR_WD:0]     iss_q;
    logic [ADR_WD:0]     pop_q;
    logic                rdv_q;
    logic [DAT_WD-1:0]   buf_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          occ_q;
    logic [1:0]          occ_d;
    logic [CNT_WD-1:0]   col_cnt_q;

    logic                        rd_ena;
    logic                        col_val;
    logic                        xfer;
    logic                        last_lane;
    logic                        pop;
    logic [DAT_WD-1:0]           head_w;
    logic [NUM_COL-1:0][COL_WD-1:0] head_lanes;

    // A word arriving this cycle counts as "in flight" for the issue limit and
    // is shown straight from rd_dat_i while the buffer is empty, so the first
    // column appears in the capture cycle and matches what gets stored.
    assign rd_ena    = (state_q == FETCH) && (iss_q != len_q) &&
                       ((occ_q + {1'b0, rdv_q}) < 2'd2);
    assign col_val   = (occ_q != 2'd0) || rdv_q;
    assign head_w    = (occ_q != 2'd0) ? buf_q[rd_ptr_q] : rd_dat_i;
    assign head_lanes = head_w;
    assign xfer      = col_val & col_rdy_i;
    assign last_lane = (col_cnt_q == CNT_WD'(NUM_COL - 1));
    assign pop       = xfer & last_lane;
    assign occ_d     = occ_q + {1'b0, rdv_q} - {1'b0, pop};

    assign busy_o    = (state_q == FETCH) || (state_q == DRAIN);
    assign done_o    = (state_q == DONE);
    assign rd_ena_o  = rd_ena;
    assign rd_adr_o  = rd_ena ? (base_q + iss_q[ADR_WD-1:0]) : '0;
    assign col_val_o = col_val;
    assign col_dat_o = col_val ? head_lanes[col_cnt_q] : '0;
    assign col_lst_o = col_val & last_lane & (pop_q == (len_q - (ADR_WD+1)'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            iss_q     <= '0;
            pop_q     <= '0;
            rdv_q     <= 1'b0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= '0;
            col_cnt_q <= '0;
        end else begin
            rdv_q <= rd_ena;
            occ_q <= occ_d;
            if (rdv_q) begin
                buf_q[wr_ptr_q] <= rd_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                pop_q    <= pop_q + (ADR_WD+1)'(1);
            end
            if (xfer)
                col_cnt_q <= last_lane ? '0 : col_cnt_q + CNT_WD'(1);
            if (rd_ena)
                iss_q <= iss_q + (ADR_WD+1)'(1);

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q  <= base_adr_i;
                        len_q   <= len_i;
                        iss_q   <= '0;
                        pop_q   <= '0;
                        state_q <= (len_i == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (rd_ena && ((iss_q + (ADR_WD+1)'(1)) == len_q))
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (occ_d == 2'd0)
                        state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_tp_rd_unpacker.sv
// Randomized bench: SRAM model plus a column-queue reference built from memory
// contents, checking data order, last flag, addresses, issue limit and timing.
module tb_sram_tp_rd_unpacker;

    localparam int ADR_WD  = 5;
    localparam int DAT_WD  = 64;
    localparam int COL_WD  = 8;
    localparam int NUM_COL = DAT_WD / COL_WD;
    localparam int DEPTH   = 1 << ADR_WD;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [ADR_WD-1:0] base_adr_i = '0;
    logic [ADR_WD:0]   len_i = '0;
    logic              busy_o, done_o, rd_ena_o, col_val_o, col_lst_o;
    logic [ADR_WD-1:0] rd_adr_o;
    logic [DAT_WD-1:0] rd_dat_i = '0;
    logic [COL_WD-1:0] col_dat_o;
    logic              col_rdy_i = 1'b0;

    sram_tp_rd_unpacker #(.ADR_WD(ADR_WD), .DAT_WD(DAT_WD), .COL_WD(COL_WD)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_adr_i(base_adr_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .rd_ena_o(rd_ena_o),
        .rd_adr_o(rd_adr_o), .rd_dat_i(rd_dat_i), .col_val_o(col_val_o),
        .col_dat_o(col_dat_o), .col_lst_o(col_lst_o), .col_rdy_i(col_rdy_i)
    );

    always #5 clk = ~clk;

    // SRAM model: registered read; garbage (not zero) when idle so the DUT must ignore it
    logic [DAT_WD-1:0] mem [DEPTH];
    logic              s_ena = 1'b0;
    logic [ADR_WD-1:0] s_adr = '0;
    int                cyc = 0;
    always @(negedge clk) begin
        s_ena <= rd_ena_o;
        s_adr <= rd_adr_o;
    end
    always @(posedge clk) begin
        rd_dat_i <= s_ena ? mem[s_adr] : {$urandom, $urandom};
        cyc      <= cyc + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference model state
    logic [COL_WD-1:0] exp_q [$];
    int  issued, words_done, ncols, done_cnt;
    int  run_base, s_cyc, f_cyc, l_cyc, d_cyc;
    bit  mon_en = 1'b0;
    bit  stall  = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rst_n && mon_en) begin
            if (rd_ena_o) begin
                check("rd_occ", 64'((issued - words_done) < 2), 64'd1);
                check("rd_adr", 64'(rd_adr_o), 64'((run_base + issued) % DEPTH));
                issued++;
            end
            if (stall && !col_val_o)
                check("val_hold", 64'(col_val_o), 64'd1);
            if (col_val_o) begin
                if (f_cyc < 0) f_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_col", 64'(col_val_o), 64'd0);
                end else begin
                    check("col_dat", 64'(col_dat_o), 64'(exp_q[0]));
                    check("col_lst", 64'(col_lst_o), 64'(exp_q.size() == 1));
                    if (col_rdy_i) begin
                        void'(exp_q.pop_front());
                        ncols++;
                        if (ncols % NUM_COL == 0) words_done++;
                        if (exp_q.size() == 0) l_cyc = cyc;
                    end
                end
            end
            stall = col_val_o && !col_rdy_i;
            if (done_o) begin
                done_cnt++;
                d_cyc = cyc;
                check("busy_at_done", 64'(busy_o), 64'd0);
            end
        end
    end

    function automatic logic [63:0] outs();
        return 64'({busy_o, done_o, rd_ena_o, col_val_o, col_lst_o, rd_adr_o, col_dat_o});
    endfunction

    // mode 0: always ready; 1: random ready; 2: random with a 20-cycle stall
    task automatic run(input int b, input int l, input int mode, input bit dup_start);
        logic [DAT_WD-1:0] w;
        exp_q.delete();
        for (int k = 0; k < l; k++) begin
            w = mem[(b + k) % DEPTH];
            for (int j = 0; j < NUM_COL; j++) exp_q.push_back(w[j*COL_WD +: COL_WD]);
        end
        issued = 0; words_done = 0; ncols = 0; done_cnt = 0;
        f_cyc = -1; l_cyc = -1; d_cyc = -1; run_base = b; stall = 1'b0;
        @(posedge clk); #1;
        start_i    = 1'b1;
        base_adr_i = b[ADR_WD-1:0];
        len_i      = l[ADR_WD:0];
        col_rdy_i  = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        s_cyc      = cyc;
        mon_en     = 1'b1;
        for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
            @(posedge clk); #1;
            if (t == 0) check("busy_after_start", 64'(busy_o), 64'(l > 0));
            start_i = dup_start && (t == 6);
            if (start_i) begin
                base_adr_i = ADR_WD'(b + 7);
                len_i      = (ADR_WD+1)'(3);
            end
            case (mode)
                0:       col_rdy_i = 1'b1;
                1:       col_rdy_i = 1'($urandom_range(0, 1));
                default: col_rdy_i = (t >= 4 && t < 24) ? 1'b0 : 1'($urandom_range(0, 1));
            endcase
        end
        start_i = 1'b0;
        if (done_cnt == 0) check("timeout", 64'd0, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("done_cnt", 64'(done_cnt), 64'd1);
        check("ncols", 64'(ncols), 64'(l * NUM_COL));
        check("issued", 64'(issued), 64'(l));
        check("q_left", 64'(exp_q.size()), 64'd0);
        check("idle_busy", 64'(busy_o), 64'd0);
        if (l > 0) begin
            check("first_lat", 64'(f_cyc - s_cyc), 64'd2);
            check("done_lat", 64'(d_cyc - l_cyc), 64'd1);
        end else begin
            check("zero_done_lat", 64'(d_cyc - s_cyc), 64'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        mem[3] = 64'h0807060504030201;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", outs(), 64'd0);
        rst_n = 1'b1;

        run(3, 1, 0, 1'b0);    // basic single word
        run(30, 4, 0, 1'b0);   // address wrap
        run(5, 4, 2, 1'b0);    // backpressure with long stall
        run(7, 0, 0, 1'b0);    // zero length
        run(12, 4, 1, 1'b1);   // second start ignored mid-run

        // reset with one read in flight
        mon_en = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1; base_adr_i = 5'd10; len_i = 6'd6;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("rd_before_rst", 64'(rd_ena_o), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid", outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", outs(), 64'd0);
        rst_n = 1'b1;
        run(10, 6, 1, 1'b0);

        for (int i = 0; i < 6; i++)
            run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)),
                int'($urandom_range(0, 2)), 1'b0);
        run(0, DEPTH, 1, 1'b0); // full address space

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
